// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flip-flop, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? 32'($clog2(WIDTH)) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sr;
    logic             r_cff;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic [WIDTH-1:0] w_sa_n;
    logic [WIDTH-1:0] w_sb_n;
    logic [WIDTH-1:0] w_sr_n;
    logic             w_cff_n;
    logic [CW-1:0]    w_cnt_n;
    logic             w_busy_n;
    logic             w_done_n;
    logic [WIDTH-1:0] w_sum_n;
    logic             w_carry_n;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_shift;

`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
    logic             w_ovf_n;
`endif

    // The single full-adder cell
    assign w_s     = r_sa[0] ^ r_sb[0] ^ r_cff;
    assign w_c     = (r_sa[0] & r_sb[0]) | (r_cff & (r_sa[0] ^ r_sb[0]));
    assign w_last  = (r_cnt == CW'(WIDTH - 1));
    // Shift-based form stays legal for WIDTH=1 where a part-select would not
    assign w_shift = (r_sr >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

    always_comb begin
        w_state_n = r_state;
        w_sa_n    = r_sa;
        w_sb_n    = r_sb;
        w_sr_n    = r_sr;
        w_cff_n   = r_cff;
        w_cnt_n   = r_cnt;
        w_busy_n  = 1'b0;
        w_done_n  = 1'b0;
        w_sum_n   = r_sum;
        w_carry_n = r_carry;
`ifdef SERIAL_ADDER_OVF_EN
        w_ovf_n   = r_ovf;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_n = S_IDLE;
                if (start) begin
                    w_state_n = S_RUN;
                    w_sa_n    = a;
                    w_sb_n    = b;
                    w_cff_n   = carry_in;
                    w_cnt_n   = '0;
                    w_busy_n  = 1'b1;
                end
            end
            S_RUN: begin
                w_sa_n  = r_sa >> 1;
                w_sb_n  = r_sb >> 1;
                w_sr_n  = w_shift;
                w_cff_n = w_c;
                w_cnt_n = r_cnt + CW'(1);
                if (w_last) begin
                    w_state_n = S_DONE;
                    w_done_n  = 1'b1;
                    w_sum_n   = w_shift;
                    w_carry_n = w_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // Carry into the MSB is the carry FF during the last bit
                    w_ovf_n   = r_cff ^ w_c;
`endif
                end else begin
                    w_busy_n = 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sr    <= '0;
            r_cff   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_sa    <= w_sa_n;
            r_sb    <= w_sb_n;
            r_sr    <= w_sr_n;
            r_cff   <= w_cff_n;
            r_cnt   <= w_cnt_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_sum   <= w_sum_n;
            r_carry <= w_carry_n;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= w_ovf_n;
`endif
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign carry = r_carry;
`ifdef SERIAL_ADDER_OVF_EN
    assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances against an
// arithmetic reference model, plus hand-computed directed expectations.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       st   [2];
    logic [7:0] ia   [2];
    logic [7:0] ib   [2];
    logic       ici  [2];

    logic       busy0, done0, carry0;
    logic [7:0] sum0;
    logic       busy1, done1, carry1;
    logic [0:0] sum1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf0, ovf1;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state (per instance)
    int         m_rem   [2];
    logic       m_busy  [2];
    logic       m_done  [2];
    logic [7:0] m_sum   [2];
    logic       m_carry [2];
    logic       m_ovf   [2];
    logic [7:0] p_sum   [2];
    logic       p_carry [2];
    logic       p_ovf   [2];
    logic       m_valid = 1'b0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (st[0]),
        .a        (ia[0]),
        .b        (ib[0]),
        .carry_in (ici[0]),
        .busy     (busy0),
        .done     (done0),
        .sum      (sum0),
        .carry    (carry0)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .overflow (ovf0)
`endif
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (st[1]),
        .a        (ia[1][0:0]),
        .b        (ib[1][0:0]),
        .carry_in (ici[1]),
        .busy     (busy1),
        .done     (done1),
        .sum      (sum1),
        .carry    (carry1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .overflow (ovf1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wid(input int i);
        return (i == 0) ? 8 : 1;
    endfunction

    // Model: result = (a+b+cin) mod 2^W, published WIDTH edges after acceptance
    always @(posedge clk) begin
        m_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_rem[i] = 0; m_busy[i] = 0; m_done[i] = 0;
                m_sum[i] = '0; m_carry[i] = 0; m_ovf[i] = 0;
            end else if (m_rem[i] != 0) begin
                m_rem[i]  = m_rem[i] - 1;
                m_done[i] = (m_rem[i] == 0);
                m_busy[i] = (m_rem[i] != 0);
                if (m_rem[i] == 0) begin
                    m_sum[i] = p_sum[i]; m_carry[i] = p_carry[i]; m_ovf[i] = p_ovf[i];
                end
            end else begin
                m_done[i] = 0;
                m_busy[i] = st[i];
                if (st[i]) begin
                    int w, mask, t;
                    logic sa, sb, ss;
                    w    = wid(i);
                    mask = (1 << w) - 1;
                    t    = (int'(ia[i]) & mask) + (int'(ib[i]) & mask) + int'(ici[i]);
                    p_sum[i]   = 8'(t & mask);
                    p_carry[i] = ((t >> w) & 1) != 0;
                    sa = ia[i][w-1]; sb = ib[i][w-1]; ss = ((t >> (w - 1)) & 1) != 0;
                    p_ovf[i]   = (sa == sb) && (ss != sa);
                    m_rem[i]   = w;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy8",  32'(busy0),  32'(m_busy[0]));
            chk("done8",  32'(done0),  32'(m_done[0]));
            chk("sum8",   32'(sum0),   32'(m_sum[0]));
            chk("carry8", 32'(carry0), 32'(m_carry[0]));
            chk("busy1",  32'(busy1),  32'(m_busy[1]));
            chk("done1",  32'(done1),  32'(m_done[1]));
            chk("sum1",   32'(sum1),   32'(m_sum[1]));
            chk("carry1", 32'(carry1), 32'(m_carry[1]));
`ifdef SERIAL_ADDER_OVF_EN
            chk("ovf8",   32'(ovf0),   32'(m_ovf[0]));
            chk("ovf1",   32'(ovf1),   32'(m_ovf[1]));
`endif
        end
    end

    task automatic wait_done0(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done0 && n < 20);
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        ia[0] = a; ib[0] = b; ici[0] = c; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        ia[0] = ~a; ib[0] = ~b; ici[0] = ~c;
    endtask

    initial begin
        int n, dones;
        logic [7:0] got_sum;
        logic       got_carry;
        logic [1:0] tbl [8];
        logic [2:0] idx;
        tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; ia[i] = '0; ib[i] = '0; ici[i] = 1'b0;
        end

        // 1. reset
        repeat (2) @(negedge clk);
        chk("t1_busy",  32'(busy0),  32'd0);
        chk("t1_done",  32'(done0),  32'd0);
        chk("t1_sum",   32'(sum0),   32'd0);
        chk("t1_carry", 32'(carry0), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("t1_ovf",   32'(ovf0),   32'd0);
`endif
        rst_n = 1'b1;

        // 2. FF + 01
        start8(8'hFF, 8'h01, 1'b0);
        wait_done0(n);
        chk("t2_latency", 32'(n), 32'd8);
        chk("t2_sum",   32'(sum0),   32'h00);
        chk("t2_carry", 32'(carry0), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
        chk("t2_ovf",   32'(ovf0),   32'd0);
`endif

        // 3. 5A + 33 + 1
        start8(8'h5A, 8'h33, 1'b1);
        wait_done0(n);
        chk("t3_latency", 32'(n), 32'd8);
        chk("t3_sum",   32'(sum0),   32'h8E);
        chk("t3_carry", 32'(carry0), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("t3_ovf",   32'(ovf0),   32'd1);
`endif

        // 4. start during RUN is ignored
        start8(8'h0F, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        ia[0] = 8'hAA; ib[0] = 8'h55; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        dones = 0; got_sum = 8'hFF; got_carry = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done0) begin
                dones++; got_sum = sum0; got_carry = carry0;
            end
        end
        chk("t4_dones", 32'(dones),     32'd1);
        chk("t4_sum",   32'(got_sum),   32'h10);
        chk("t4_carry", 32'(got_carry), 32'd0);
        chk("t4_idle",  32'(busy0),     32'd0);

        // 5. reset mid-RUN aborts
        start8(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_busy",  32'(busy0),  32'd0);
        chk("t5_done",  32'(done0),  32'd0);
        chk("t5_sum",   32'(sum0),   32'd0);
        chk("t5_carry", 32'(carry0), 32'd0);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done0) dones++;
        end
        chk("t5_no_done", 32'(dones), 32'd0);

        // 6. WIDTH=1 full-adder sweep, start held high
        @(negedge clk);
        idx = 3'd0;
        ia[1] = {7'd0, idx[2]}; ib[1] = {7'd0, idx[1]}; ici[1] = idx[0]; st[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t6_busy", 32'(busy1), 32'd1);
            if (i < 7) begin
                idx = 3'(i + 1);
                ia[1] = {7'd0, idx[2]}; ib[1] = {7'd0, idx[1]}; ici[1] = idx[0];
            end else begin
                st[1] = 1'b0;
            end
            @(negedge clk);
            chk("t6_done", 32'(done1), 32'd1);
            chk("t6_fa",   32'({carry1, sum1}), 32'(tbl[i]));
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
